// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Brief    : Shared slot map, state encoding and read-select codes for the
//            Hack MMIO decoder.
// Revision : 1.0
// ============================================================================
package mmio_pkg;

    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_MASK = 16'hC000;
    localparam logic [15:0] LED_BASE = 16'h4000;
    localparam logic [15:0] LED_MASK = 16'hFFF0;
    localparam logic [15:0] KBD_BASE = 16'h6000;
    localparam logic [15:0] KBD_MASK = 16'hFFFF;
    localparam logic [15:0] EXT_BASE = 16'h5000;
    localparam logic [15:0] EXT_MASK = 16'hF000;

    localparam int SEL_W  = 8;
    localparam int WAIT_W = 8;

    // Read-select code that steers no slot, so inM reads back as zero.
    localparam logic [SEL_W-1:0] RD_SEL_NONE = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mmio_slot_match.sv
`default_nettype none
// ============================================================================
// Module   : mmio_slot_match
// Brief    : Per-slot base/mask comparators with lowest-index priority.
// Revision : 1.0
// ============================================================================
module mmio_slot_match
    import mmio_pkg::*;
#(
    parameter int                          ADDR_W    = 16,
    parameter int                          N_SLOTS   = 4,
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_BASE = {EXT_BASE, KBD_BASE, LED_BASE, RAM_BASE},
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_MASK = {EXT_MASK, KBD_MASK, LED_MASK, RAM_MASK}
) (
    input  logic [ADDR_W-1:0]  address,
    output logic [N_SLOTS-1:0] hit,
    output logic [SEL_W-1:0]   hit_idx,
    output logic               any_hit
);

    logic [N_SLOTS-1:0] w_raw_hit;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_cmp
        assign w_raw_hit[i] = ((address & SLOT_MASK[i*ADDR_W +: ADDR_W])
                               == SLOT_BASE[i*ADDR_W +: ADDR_W]);
    end

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        hit     = '0;
        hit_idx = RD_SEL_NONE;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (w_raw_hit[i]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign any_hit = |w_raw_hit;

endmodule
`default_nettype wire

// File: rtl/mmio_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_decoder
// Brief    : Hack CPU data-port decoder with wait states, timeout and sticky
//            bus-fault capture.
// Revision : 1.0
// ============================================================================
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter int                          ADDR_W    = 16,
    parameter int                          DATA_W    = 16,
    parameter int                          N_SLOTS   = 4,
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_BASE = {EXT_BASE, KBD_BASE, LED_BASE, RAM_BASE},
    parameter logic [N_SLOTS*ADDR_W-1:0]   SLOT_MASK = {EXT_MASK, KBD_MASK, LED_MASK, RAM_MASK},
    parameter int                          WAIT_MAX  = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       writeM,
    input  logic                       readM,
    output logic [DATA_W-1:0]          inM,
    output logic                       cpu_stall,
    output logic [N_SLOTS-1:0]         slot_sel,
    output logic                       slot_we,
    input  logic [N_SLOTS*DATA_W-1:0]  slot_rdata,
    input  logic [N_SLOTS-1:0]         slot_ready,
    output logic                       fault,
    output logic [ADDR_W-1:0]          fault_addr,
    output logic [7:0]                 fault_count,
    input  logic                       fault_clear
);

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [N_SLOTS-1:0]  r_slot_oh;
    logic [SEL_W-1:0]    r_slot_idx;
    logic                r_is_read;
    logic [ADDR_W-1:0]   r_addr;
    logic [SEL_W-1:0]    r_rd_sel;
    logic                r_rd_valid;

    logic [N_SLOTS-1:0]  w_hit;
    logic [SEL_W-1:0]    w_hit_idx;
    logic                w_any_hit;
    logic                w_access;
    logic [N_SLOTS-1:0]  w_sel;
    logic                w_stall;
    logic                w_complete;
    logic                w_miss;
    logic                w_timeout;
    logic                w_enter_wait;
    logic [SEL_W-1:0]    w_cmp_idx;
    logic                w_cmp_read;
    logic                w_fault_evt;
    logic [ADDR_W-1:0]   w_fault_addr;

    mmio_slot_match #(
        .ADDR_W    (ADDR_W),
        .N_SLOTS   (N_SLOTS),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_match (
        .address (address),
        .hit     (w_hit),
        .hit_idx (w_hit_idx),
        .any_hit (w_any_hit)
    );

    assign w_access = writeM | readM;

    always_comb begin
        w_next_state = r_state;
        w_sel        = '0;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        w_miss       = 1'b0;
        w_timeout    = 1'b0;
        w_enter_wait = 1'b0;
        w_cmp_idx    = r_slot_idx;
        w_cmp_read   = r_is_read;
        case (r_state)
            ST_IDLE: begin
                w_cmp_idx  = w_hit_idx;
                w_cmp_read = readM & ~writeM;
                if (w_access) begin
                    if (w_any_hit) begin
                        w_sel = w_hit;
                        if (|(w_hit & slot_ready)) begin
                            w_complete = 1'b1;
                        end else begin
                            w_stall      = 1'b1;
                            w_enter_wait = 1'b1;
                            w_next_state = ST_WAIT;
                        end
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // The CPU is held, so the latched slot is authoritative here.
                w_sel = r_slot_oh;
                if (|(r_slot_oh & slot_ready)) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == WAIT_W'(WAIT_MAX)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_fault_evt  = w_miss | w_timeout;
    assign w_fault_addr = (r_state == ST_IDLE) ? address : r_addr;

    // Gated by rst_n so the peripheral sees the select drop asynchronously.
    assign slot_sel  = rst_n ? w_sel : '0;
    assign cpu_stall = rst_n & w_stall;
    assign slot_we   = writeM & (|slot_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_slot_oh   <= '0;
            r_slot_idx  <= '0;
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_rd_sel    <= '0;
            r_rd_valid  <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= '0;
            fault_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rd_valid <= 1'b0;

            if (w_enter_wait) begin
                r_slot_oh  <= w_hit;
                r_slot_idx <= w_hit_idx;
                r_is_read  <= readM & ~writeM;
                r_addr     <= address;
                r_wait_cnt <= WAIT_W'(1);
            end else if (r_state == ST_WAIT && w_stall) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end

            if (w_complete) begin
                r_rd_valid <= w_cmp_read;
                r_rd_sel   <= w_cmp_idx;
            end else if (w_fault_evt) begin
                r_rd_valid <= 1'b1;
                r_rd_sel   <= RD_SEL_NONE;
            end

            if (w_fault_evt) begin
                fault <= 1'b1;
                if (!fault || fault_clear) begin
                    fault_addr <= w_fault_addr;
                end
                if (fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'd1;
                end
            end else if (fault_clear) begin
                fault      <= 1'b0;
                fault_addr <= '0;
            end
        end
    end

    always_comb begin
        inM = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (r_rd_valid && (r_rd_sel == SEL_W'(i))) begin
                inM = slot_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_decoder
// Brief    : Self-checking bench for mmio_decoder (vector table + sequences).
// Revision : 1.0
// ============================================================================
module tb_mmio_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address;
    logic        writeM;
    logic        readM;
    logic [15:0] inM;
    logic        cpu_stall;
    logic [3:0]  slot_sel;
    logic        slot_we;
    logic [63:0] slot_rdata;
    logic [3:0]  slot_ready;
    logic        fault;
    logic [15:0] fault_addr;
    logic [7:0]  fault_count;
    logic        fault_clear;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [3:0]  rdy;
        logic [3:0]  e_sel;
        logic        e_stall;
        logic        e_we;
        logic [15:0] e_inm;
        logic        e_fault;
        logic [15:0] e_faddr;
        logic [7:0]  e_fcnt;
    } vec_t;

    vec_t vecs[10];

    mmio_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .writeM      (writeM),
        .readM       (readM),
        .inM         (inM),
        .cpu_stall   (cpu_stall),
        .slot_sel    (slot_sel),
        .slot_we     (slot_we),
        .slot_rdata  (slot_rdata),
        .slot_ready  (slot_ready),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fault_count (fault_count),
        .fault_clear (fault_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One bus cycle: check combinational outputs, queue the inM expected
    // after the edge, then pop and compare it.
    task automatic cyc(input string nm, input logic [15:0] a, input logic w, input logic r,
                       input logic [3:0] rdy, input logic [3:0] e_sel, input logic e_stall,
                       input logic e_we, input logic [15:0] e_inm);
        logic [15:0] e;
        address    = a;
        writeM     = w;
        readM      = r;
        slot_ready = rdy;
        #2;
        chk({nm, ".sel"},   32'(slot_sel),  32'(e_sel));
        chk({nm, ".stall"}, 32'(cpu_stall), 32'(e_stall));
        chk({nm, ".we"},    32'(slot_we),   32'(e_we));
        exp_q.push_back(e_inm);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({nm, ".inM"}, 32'(inM), 32'(e));
    endtask

    task automatic chk_fault(input string nm, input logic f, input logic [15:0] fa,
                             input logic [7:0] fc);
        chk({nm, ".fault"},      32'(fault),       32'(f));
        chk({nm, ".fault_addr"}, 32'(fault_addr),  32'(fa));
        chk({nm, ".fault_cnt"},  32'(fault_count), 32'(fc));
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 1'b1, 4'hF, 4'b0001, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 8'd0};
        vecs[1] = '{16'h1234, 1'b0, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0};
        vecs[2] = '{16'h400F, 1'b1, 1'b0, 4'hF, 4'b0010, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd0};
        vecs[3] = '{16'h3FFF, 1'b0, 1'b1, 4'hF, 4'b0001, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000, 8'd0};
        vecs[4] = '{16'h4005, 1'b0, 1'b1, 4'hF, 4'b0010, 1'b0, 1'b0, 16'h1111, 1'b0, 16'h0000, 8'd0};
        vecs[5] = '{16'h6000, 1'b0, 1'b1, 4'hF, 4'b0100, 1'b0, 1'b0, 16'h2222, 1'b0, 16'h0000, 8'd0};
        vecs[6] = '{16'h5ABC, 1'b0, 1'b1, 4'hF, 4'b1000, 1'b0, 1'b0, 16'h3333, 1'b0, 16'h0000, 8'd0};
        vecs[7] = '{16'h6000, 1'b1, 1'b1, 4'hF, 4'b0100, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd0};
        vecs[8] = '{16'h4010, 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4010, 8'd1};
        vecs[9] = '{16'h7000, 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4010, 8'd2};

        rst_n       = 1'b0;
        address     = '0;
        writeM      = 1'b0;
        readM       = 1'b0;
        slot_ready  = '0;
        fault_clear = 1'b0;
        slot_rdata  = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};

        #12;
        chk("reset.sel", 32'(slot_sel), 32'h0);
        chk("reset.stall", 32'(cpu_stall), 32'h0);
        chk("reset.inM", 32'(inM), 32'h0);
        chk_fault("reset", 1'b0, 16'h0000, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cyc(nm, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].rdy,
                vecs[i].e_sel, vecs[i].e_stall, vecs[i].e_we, vecs[i].e_inm);
            chk_fault(nm, vecs[i].e_fault, vecs[i].e_faddr, vecs[i].e_fcnt);
        end

        fault_clear = 1'b1;
        cyc("clr", 16'h0000, 1'b0, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 16'h0000);
        fault_clear = 1'b0;
        chk_fault("clr", 1'b0, 16'h0000, 8'd2);

        for (int i = 0; i < 3; i++)
            cyc($sformatf("wait%0d", i), 16'h6000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0, 16'h0000);
        cyc("wait_done", 16'h6000, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 16'h2222);
        cyc("wait_after", 16'h6000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
        chk_fault("wait", 1'b0, 16'h0000, 8'd2);

        for (int i = 0; i < 15; i++)
            cyc($sformatf("tmo%0d", i), 16'h5000, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0, 16'h0000);
        cyc("tmo_abort", 16'h5000, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 16'h0000);
        chk_fault("tmo", 1'b1, 16'h5000, 8'd3);
        cyc("tmo_after", 16'h5000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);

        fault_clear = 1'b1;
        cyc("clr_miss", 16'h8000, 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 16'h0000);
        fault_clear = 1'b0;
        chk_fault("clr_miss", 1'b1, 16'h8000, 8'd4);

        for (int i = 0; i < 256; i++)
            cyc("sat", 16'h9000, 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 16'h0000);
        chk_fault("sat", 1'b1, 16'h8000, 8'd255);

        cyc("rstw_enter", 16'h5000, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0, 16'h0000);
        #2;
        chk("rstw_pre.sel", 32'(slot_sel), 32'b1000);
        chk("rstw_pre.stall", 32'(cpu_stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstw.sel", 32'(slot_sel), 32'h0);
        chk("rstw.stall", 32'(cpu_stall), 32'h0);
        chk("rstw.inM", 32'(inM), 32'h0);
        chk_fault("rstw", 1'b0, 16'h0000, 8'd0);
        readM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst", 16'h0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 16'hBEEF);
        cyc("post_rst_idle", 16'h0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_decoder.md
Name: mmio_decoder

Overview:
- Parametrised memory-mapped I/O decoder between the Hack CPU data port (address/writeM/readM/inM) and N_SLOTS peripheral slots: RAM, LEDs, keyboard and future devices.
- Each slot is selected by a base/mask match; one slot is chosen by priority.
- Adds behaviour the fixed RAM/LED decoder lacks:
  - registered read-data steering, aligned to 1-cycle synchronous peripheral reads;
  - per-slot ready/wait handshake that stalls the CPU;
  - bounded wait timeout;
  - sticky bus-fault capture for unmapped or timed-out accesses.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- N_SLOTS, 4, number of peripheral slots.
- SLOT_BASE, {16'h5000,16'h6000,16'h4000,16'h0000}, packed N_SLOTS*ADDR_W base addresses; slot 0 is in the LSBs.
- SLOT_MASK, {16'hF000,16'hFFFF,16'hFFF0,16'hC000}, packed compare masks.
- WAIT_MAX, 15, maximum wait cycles before timeout fault (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  CPU data address
- writeM  in  1  CPU write strobe
- readM  in  1  CPU read strobe
- inM  out  DATA_W  read data to CPU
- cpu_stall  out  1  CPU must hold address/strobes and not advance
- slot_sel  out  N_SLOTS  one-hot slot enable
- slot_we  out  1  write enable qualified to the selected slot
- slot_rdata  in  N_SLOTS*DATA_W  packed per-slot read data, valid 1 cycle after accepted select
- slot_ready  in  N_SLOTS  per-slot ready; 1 = access completes this cycle
- fault  out  1  sticky bus fault
- fault_addr  out  ADDR_W  address of the first fault since last clear
- fault_count  out  8  saturating fault counter
- fault_clear  in  1  clears fault and fault_addr; counter is not cleared

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wait counter=0, rd_sel_q=0, rd_valid_q=0.
  - fault=0, fault_addr=0, fault_count=0.
  - Outputs: slot_sel=0, slot_we=0, cpu_stall=0, inM=0.
- Access definition: access = writeM | readM. If both strobes are high, the access is a write.
- Hit decode: hit[i] = ((address & MASK[i]) == BASE[i]); the lowest index wins. A miss is an access with no hit.
- slot_sel:
  - Combinational one-hot of the winning slot while access is active in IDLE, or the latched slot in WAIT.
  - slot_sel=0 when there is no access, or on a miss.
- slot_we = writeM & |slot_sel.
- State IDLE:
  - Access, hit, slot_ready[i]=1: completes in the same cycle; cpu_stall=0. Latch rd_sel_q=i and rd_valid_q=readM&~writeM.
  - Access, hit, slot_ready[i]=0: cpu_stall=1 combinationally; latch slot i; go to WAIT with counter=1.
  - Miss: fault=1; fault_addr=address if fault was 0; fault_count+1 (saturates at 255); rd_valid_q=1 with rd_sel forced to "none" so inM=0; no stall.
- State WAIT:
  - slot_sel stays at the latched slot; cpu_stall=1.
  - slot_ready=1: complete as in IDLE, cpu_stall=0 this cycle, return to IDLE.
  - Otherwise counter+1. When counter==WAIT_MAX and still not ready: abort, record a fault as for a miss, cpu_stall=0, return to IDLE, inM=0 next cycle.
- inM:
  - Combinational mux of slot_rdata[rd_sel_q] when rd_valid_q=1, else 0.
  - Read latency is exactly 1 cycle after the completing cycle.
  - rd_valid_q clears on any cycle without a completing read.
- fault_clear:
  - Clears fault and fault_addr on the next edge.
  - A fault and fault_clear in the same cycle: the new fault wins (fault=1, fault_addr=new address).
- Reset mid-WAIT: aborts immediately to IDLE with all outputs at their reset values; the peripheral sees slot_sel drop asynchronously.
- Address or strobe change during a stall is a CPU protocol violation. The decoder ignores it and stays on the latched slot.

Decomposition:
- Shared package mmio_pkg:
  - default slot map constants (RAM_BASE/MASK, LED_BASE/MASK, KBD_BASE/MASK, EXT_BASE/MASK);
  - state encoding (IDLE=0, WAIT=1);
  - the RD_SEL_NONE code.
- One natural sub-module: mmio_slot_match, a per-slot base/mask comparator plus priority encoder producing one-hot hit and a binary index.

Test Plan:
- Read 0x1234, slot0 ready=1, slot_rdata0=0xBEEF -> slot_sel=0001 same cycle, cpu_stall=0, inM=0xBEEF next cycle, then 0.
- Write 0x400F, slot1 ready=1 -> slot_sel=0010, slot_we=1. Write 0x4010 -> miss, slot_sel=0000, fault=1, fault_addr=0x4010, fault_count=1.
- Read 0x6000 with slot2 ready low 3 cycles -> cpu_stall=1 for 3 cycles, slot_sel=0100 held; inM=slot_rdata2 one cycle after ready rises.
- Read 0x5000 with slot3 never ready -> cpu_stall high 15 cycles then drops, fault=1, fault_addr=0x5000, inM=0.
- fault_clear pulsed with a simultaneous miss at 0x8000 -> fault stays 1, fault_addr=0x8000. 256 further misses -> fault_count saturates at 255.
- rst_n asserted in WAIT -> slot_sel, cpu_stall, fault, fault_count all 0 immediately. After release, read 0x0000 completes normally.
